cpu_fetch_unit: RTL and testbench
=================================

Name: cpu_fetch_unit

Overview:
Owns the program counter, instruction register and the decoder's State bit for the single-issue 16-bit CPU. Fetches instructions from instruction memory over a req/ready handshake and presents IR and State to the decoder. Consumes the decoder's PS, IR_L, NS and K outputs to sequence the next fetch. Sits directly upstream of the decoder and closes the fetch/decode loop.

Parameters:
AW, 16, PC / instruction-address width
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
PS  in  2  PC select from decoder: 00 hold, 01 PC+1, 10 PC+1+K, 11 RA
IR_L  in  1  from decoder: 1 = instruction retires and the next one is fetched, 0 = halt
NS  in  1  from decoder: next value of State
K  in  16  branch offset from decoder, two's complement
RA  in  AW  register-sourced jump target (register file A port)
Stall  in  1  datapath stall; freezes the EXEC phase
imem_rdata  in  16  instruction word from memory
imem_ready  in  1  memory completes the read this cycle
imem_addr  out  AW  fetch address
imem_req  out  1  fetch request
IR  out  16  instruction register, to decoder
State  out  1  decoder state bit
IR_valid  out  1  IR holds a fetched instruction being executed
PC  out  AW  current program counter
Halted  out  1  core halted

Behaviour:
- Phases: FETCH, EXEC, HALT. All state is registered and all updates happen on the rising edge of clk.
- Reset, with highest priority over everything:
  - phase = FETCH, PC = RESET_PC, IR = 16'h0000, State = 0, IR_valid = 0, Halted = 0.
  - imem_req is forced to 0 while reset = 1.
  - imem_ready is ignored during a reset cycle.
  - Reset asserted mid-fetch or mid-EXEC aborts the operation with no PC or IR update.
- FETCH:
  - imem_req = 1 and imem_addr = PC, held stable until imem_ready.
  - On a cycle with req & ready: IR <= imem_rdata, IR_valid <= 1, phase <= EXEC.
  - Without ready: nothing else changes.
  - Stall is ignored in FETCH.
  - Minimum fetch latency is 1 cycle (ready in the first req cycle). The IR is visible to the decoder in the cycle after the handshake.
- EXEC, with conditions evaluated in this priority order:
  - Stall = 1: hold PC, IR, State and phase.
  - NS = 1: State <= 1; stay in EXEC; PC held and PS ignored (multi-cycle instruction).
  - NS = 0 and IR_L = 1: State <= 0, PC <= next_pc, IR_valid <= 0, phase <= FETCH.
  - NS = 0 and IR_L = 0: State <= 0, PC <= next_pc, phase <= HALT, Halted <= 1.
  - imem_req = 0 throughout EXEC.
- next_pc, computed mod 2^AW (wrap-around, no overflow flag):
  - 00 -> PC
  - 01 -> PC+1
  - 10 -> PC + 1 + K[AW-1:0]
  - 11 -> RA
- HALT:
  - imem_req = 0; PC, IR and State frozen; IR_valid = 1; Halted = 1.
  - Only reset leaves HALT.
- Boundary cases:
  - PC = 16'hFFFF with PS = 01 wraps to 16'h0000.
  - K = 16'h8000 is a legal backward offset.
  - imem_ready without imem_req is ignored.
  - imem_rdata is sampled only on the handshake cycle.

Test Plan:
- Reset, then ready with 0 wait states; imem_rdata = 16'h0805, decoder drives PS = 01, IR_L = 1, NS = 0 -> imem_req rises the cycle after reset drops, IR = 16'h0805 next cycle, PC = 0001 after EXEC, second fetch addr = 0001.
- Memory holds ready low for 3 cycles -> imem_req and imem_addr stable for 4 cycles, IR unchanged until the handshake, no PC change.
- PC = 0010, PS = 10, K = 16'hFFFC -> PC = 000D; PS = 11, RA = 1234 -> PC = 1234; PC = FFFF, PS = 01 -> PC = 0000.
- EXEC with NS = 1 for 2 cycles then NS = 0, IR_L = 1 -> State = 1 for those cycles, PC held, fetch only after NS = 0; Stall = 1 mid-EXEC holds everything.
- IR_L = 0, PS = 00 in EXEC -> Halted = 1, imem_req stays 0 for 20 cycles; reset -> PC = RESET_PC, Halted = 0, fetch resumes.
- Reset asserted in a FETCH cycle where imem_ready = 1 -> IR stays 0000, IR_valid = 0, PC = RESET_PC.

Source files
------------

// File: rtl/cpu_fetch_unit_if.sv
// Instruction-memory read port: address/request out of the fetch unit,
// data/ready back from memory.
interface cpu_fetch_unit_if #(
  parameter int AW = 16
);
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic [15:0]   imem_rdata;
  logic          imem_ready;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/cpu_fetch_unit.sv
// Fetch unit: owns PC, IR and the decoder State bit. It fetches over the
// imem req/ready handshake, then lets the decoder's PS/IR_L/NS/K outputs
// decide the next PC, whether to refetch, and whether to halt.
module cpu_fetch_unit #(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        PS,
  input  logic              IR_L,
  input  logic              NS,
  input  logic [15:0]       K,
  input  logic [AW-1:0]     RA,
  input  logic              Stall,
  cpu_fetch_unit_if.master  mem,
  output logic [15:0]       IR,
  output logic              State,
  output logic              IR_valid,
  output logic [AW-1:0]     PC,
  output logic              Halted
);

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} phase_t;

  phase_t        phase, phase_d;
  logic [AW-1:0] pc_d, next_pc, k_ext;
  logic [15:0]   ir_d;
  logic          state_d, ir_valid_d, halted_d;

  // K is a 16-bit signed offset; fit it to the address width
  if (AW <= 16) begin : g_k_trunc
    assign k_ext = K[AW-1:0];
  end else begin : g_k_sext
    assign k_ext = {{(AW-16){K[15]}}, K};
  end

  // Address is the PC itself; request only while fetching and never in reset
  assign mem.imem_addr = PC;
  assign mem.imem_req  = (phase == FETCH) && !reset;

  // Next-PC select, wraps modulo 2^AW
  always_comb begin
    next_pc = PC;
    case (PS)
      2'b00:   next_pc = PC;
      2'b01:   next_pc = PC + AW'(1);
      2'b10:   next_pc = PC + AW'(1) + k_ext;
      default: next_pc = RA;
    endcase
  end

  // Phase sequencing and next values of all architectural state
  always_comb begin
    phase_d    = phase;
    pc_d       = PC;
    ir_d       = IR;
    state_d    = State;
    ir_valid_d = IR_valid;
    halted_d   = Halted;
    case (phase)
      FETCH: begin
        // rdata is only captured on the handshake cycle; Stall has no effect here
        if (mem.imem_ready) begin
          ir_d       = mem.imem_rdata;
          ir_valid_d = 1'b1;
          phase_d    = EXEC;
        end
      end
      EXEC: begin
        if (!Stall) begin
          if (NS) begin
            // multi-cycle instruction: PC held, PS ignored
            state_d = 1'b1;
          end else begin
            state_d = 1'b0;
            pc_d    = next_pc;
            if (IR_L) begin
              ir_valid_d = 1'b0;
              phase_d    = FETCH;
            end else begin
              halted_d = 1'b1;
              phase_d  = HALT;
            end
          end
        end
      end
      HALT: ; // frozen until reset
      default: phase_d = FETCH;
    endcase
  end

  // State register; reset overrides any in-flight fetch or execute
  always_ff @(posedge clk) begin
    if (reset) begin
      phase    <= FETCH;
      PC       <= RESET_PC;
      IR       <= 16'h0000;
      State    <= 1'b0;
      IR_valid <= 1'b0;
      Halted   <= 1'b0;
    end else begin
      phase    <= phase_d;
      PC       <= pc_d;
      IR       <= ir_d;
      State    <= state_d;
      IR_valid <= ir_valid_d;
      Halted   <= halted_d;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit: reset, zero/multi wait-state fetches,
// PC select arithmetic and wrap, multi-cycle/stall EXEC, halt, reset abort.
module tb_cpu_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PS;
  logic        IR_L, NS, Stall;
  logic [15:0] K, RA;
  logic [15:0] IR, PC;
  logic        State, IR_valid, Halted;
  int          checks = 0;
  int          errors = 0;

  cpu_fetch_unit_if #(.AW(16)) mem ();

  cpu_fetch_unit #(.AW(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .PS(PS), .IR_L(IR_L), .NS(NS), .K(K), .RA(RA),
    .Stall(Stall), .mem(mem), .IR(IR), .State(State), .IR_valid(IR_valid),
    .PC(PC), .Halted(Halted)
  );

  always #5 clk = ~clk;

  // advance one edge and settle away from it
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // one zero-wait-state handshake delivering word w
  task automatic do_fetch(input logic [15:0] w);
    mem.imem_ready = 1'b1; mem.imem_rdata = w;
    tick();
    mem.imem_ready = 1'b0; mem.imem_rdata = 16'hDEAD;
  endtask

  // one retiring EXEC cycle with the given PC select
  task automatic do_exec(input logic [1:0] ps, input logic [15:0] k, input logic [15:0] ra);
    PS = ps; K = k; RA = ra; NS = 1'b0; IR_L = 1'b1; Stall = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; mem.imem_ready = 1'b1; mem.imem_rdata = 16'h0805;
    PS = 2'b01; IR_L = 1'b1; NS = 1'b0; K = '0; RA = '0; Stall = 1'b0;
    tick(); tick();
    checks++; if (mem.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", mem.imem_req); end
    checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h exp 0000", PC); end
    checks++; if (IR !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h exp 0000", IR); end
    checks++; if ({State, IR_valid, Halted} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {State, IR_valid, Halted}); end
  endtask

  task automatic test_basic_fetch();
    reset = 1'b0; #1;
    checks++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 16'h0000) begin errors++; $display("FAIL first_req: got req=%b addr=%h exp 1/0000", mem.imem_req, mem.imem_addr); end
    tick(); // handshake with ready already high
    mem.imem_ready = 1'b0;
    checks++; if (IR !== 16'h0805 || IR_valid !== 1'b1) begin errors++; $display("FAIL first_ir: got %h/%b exp 0805/1", IR, IR_valid); end
    checks++; if (mem.imem_req !== 1'b0) begin errors++; $display("FAIL exec_req: got %b exp 0", mem.imem_req); end
    tick(); // EXEC with PS=01
    checks++; if (PC !== 16'h0001 || IR_valid !== 1'b0) begin errors++; $display("FAIL exec_pc: got %h/%b exp 0001/0", PC, IR_valid); end
    checks++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 16'h0001) begin errors++; $display("FAIL second_req: got req=%b addr=%h exp 1/0001", mem.imem_req, mem.imem_addr); end
  endtask

  task automatic test_wait_states();
    mem.imem_ready = 1'b0; mem.imem_rdata = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 16'h0001) begin errors++; $display("FAIL wait_req%0d: got req=%b addr=%h exp 1/0001", i, mem.imem_req, mem.imem_addr); end
      checks++; if (IR !== 16'h0805 || PC !== 16'h0001 || IR_valid !== 1'b0) begin errors++; $display("FAIL wait_hold%0d: got IR=%h PC=%h v=%b exp 0805/0001/0", i, IR, PC, IR_valid); end
    end
    do_fetch(16'h1111);
    checks++; if (IR !== 16'h1111 || IR_valid !== 1'b1) begin errors++; $display("FAIL wait_ir: got %h/%b exp 1111/1", IR, IR_valid); end
  endtask

  task automatic test_pc_select();
    do_exec(2'b11, 16'h0000, 16'h0010);
    checks++; if (PC !== 16'h0010) begin errors++; $display("FAIL pc_ra10: got %h exp 0010", PC); end
    do_fetch(16'h2222);
    do_exec(2'b10, 16'hFFFC, 16'h0000);
    checks++; if (PC !== 16'h000D) begin errors++; $display("FAIL pc_branch: got %h exp 000D", PC); end
    do_fetch(16'h3333);
    do_exec(2'b11, 16'h0000, 16'h1234);
    checks++; if (PC !== 16'h1234) begin errors++; $display("FAIL pc_ra: got %h exp 1234", PC); end
    do_fetch(16'h4444);
    do_exec(2'b10, 16'h8000, 16'h0000);
    checks++; if (PC !== 16'h9235) begin errors++; $display("FAIL pc_k8000: got %h exp 9235", PC); end
    do_fetch(16'h5555);
    do_exec(2'b11, 16'h0000, 16'hFFFF);
    do_fetch(16'h6666);
    do_exec(2'b01, 16'h0000, 16'h0000);
    checks++; if (PC !== 16'h0000) begin errors++; $display("FAIL pc_wrap: got %h exp 0000", PC); end
  endtask

  task automatic test_multicycle_stall();
    do_fetch(16'h7777);
    PS = 2'b01; IR_L = 1'b1; NS = 1'b1; Stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (State !== 1'b1 || PC !== 16'h0000 || mem.imem_req !== 1'b0) begin errors++; $display("FAIL ns_hold%0d: got S=%b PC=%h req=%b exp 1/0000/0", i, State, PC, mem.imem_req); end
    end
    NS = 1'b0; Stall = 1'b1;
    tick(); tick();
    checks++; if (State !== 1'b1 || PC !== 16'h0000 || IR !== 16'h7777 || mem.imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold: got S=%b PC=%h IR=%h req=%b exp 1/0000/7777/0", State, PC, IR, mem.imem_req); end
    Stall = 1'b0;
    tick();
    checks++; if (State !== 1'b0 || PC !== 16'h0001 || mem.imem_req !== 1'b1) begin errors++; $display("FAIL ns_release: got S=%b PC=%h req=%b exp 0/0001/1", State, PC, mem.imem_req); end
  endtask

  task automatic test_halt();
    do_fetch(16'h0F0F);
    PS = 2'b00; IR_L = 1'b0; NS = 1'b0; Stall = 1'b0;
    tick();
    checks++; if (Halted !== 1'b1 || PC !== 16'h0001 || IR_valid !== 1'b1) begin errors++; $display("FAIL halt_enter: got H=%b PC=%h v=%b exp 1/0001/1", Halted, PC, IR_valid); end
    mem.imem_ready = 1'b1; mem.imem_rdata = 16'hBBBB; PS = 2'b01; IR_L = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem.imem_req !== 1'b0 || IR !== 16'h0F0F || PC !== 16'h0001 || Halted !== 1'b1) begin
        errors++; $display("FAIL halt_frozen%0d: got req=%b IR=%h PC=%h H=%b exp 0/0F0F/0001/1", i, mem.imem_req, IR, PC, Halted);
      end
    end
    checks++;
    reset = 1'b1; tick(); reset = 1'b0; mem.imem_ready = 1'b0; #1;
    checks++; if (PC !== 16'h0000 || Halted !== 1'b0 || IR_valid !== 1'b0) begin errors++; $display("FAIL halt_reset: got PC=%h H=%b v=%b exp 0000/0/0", PC, Halted, IR_valid); end
    checks++; if (mem.imem_req !== 1'b1 || mem.imem_addr !== 16'h0000) begin errors++; $display("FAIL halt_resume: got req=%b addr=%h exp 1/0000", mem.imem_req, mem.imem_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    do_fetch(16'h1212);
    do_exec(2'b11, 16'h0000, 16'h0040);
    checks++; if (mem.imem_addr !== 16'h0040 || mem.imem_req !== 1'b1) begin errors++; $display("FAIL abort_setup: got addr=%h req=%b exp 0040/1", mem.imem_addr, mem.imem_req); end
    reset = 1'b1; mem.imem_ready = 1'b1; mem.imem_rdata = 16'hBEEF; #1;
    checks++; if (mem.imem_req !== 1'b0) begin errors++; $display("FAIL abort_req: got %b exp 0", mem.imem_req); end
    tick();
    reset = 1'b0; mem.imem_ready = 1'b0;
    checks++; if (IR !== 16'h0000 || IR_valid !== 1'b0 || PC !== 16'h0000) begin errors++; $display("FAIL abort_state: got IR=%h v=%b PC=%h exp 0000/0/0000", IR, IR_valid, PC); end
  endtask

  initial begin
    reset = 1'b1; mem.imem_ready = 1'b0; mem.imem_rdata = '0;
    PS = '0; IR_L = 1'b0; NS = 1'b0; K = '0; RA = '0; Stall = 1'b0;
    test_reset();
    test_basic_fetch();
    test_wait_states();
    test_pc_select();
    test_multicycle_stall();
    test_halt();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
